// File: rtl/fetch_queue.sv
// In-order (pc, instruction) buffer between the i_cache output and decode.
// Absorbs decode stalls and is cleared on any PC redirect.
module fetch_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_valid,
    input  logic [ADDR_WIDTH-1:0]    i_pc,
    input  logic [DATA_WIDTH-1:0]    i_instr,
    output logic                     o_ready,
    output logic                     o_almost_full,
    output logic                     o_valid,
    output logic [ADDR_WIDTH-1:0]    o_pc,
    output logic [DATA_WIDTH-1:0]    o_instr,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Handshake: a push transfers when i_valid & o_ready and no flush; a pop
    // transfers when o_valid & i_ready and no flush. Neither ready nor valid
    // depends combinationally on the other side's inputs.
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [ADDR_WIDTH-1:0]  pc_mem_q    [DEPTH];
    logic [DATA_WIDTH-1:0]  instr_mem_q [DEPTH];

    logic push;
    logic pop;

    assign o_ready       = (count_q < CNT_W'(DEPTH));
    assign o_almost_full = (count_q >= CNT_W'(DEPTH - 1));
    assign o_valid       = (count_q != '0);
    assign o_count       = count_q;

    assign o_pc    = o_valid ? pc_mem_q[head_q]    : '0;
    assign o_instr = o_valid ? instr_mem_q[head_q] : '0;

    assign push = i_valid & o_ready & ~i_flush;
    assign pop  = o_valid & i_ready & ~i_flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (i_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is left unreset; o_valid masks whatever it holds.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[tail_q]    <= i_pc;
            instr_mem_q[tail_q] <= i_instr;
        end
    end

`ifndef SYNTHESIS
    logic [ADDR_WIDTH-1:0] last_pc_q;
    logic                  last_pc_vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pc_q     <= '0;
            last_pc_vld_q <= 1'b0;
        end else if (i_flush) begin
            last_pc_vld_q <= 1'b0;
        end else if (pop) begin
            last_pc_q     <= o_pc;
            last_pc_vld_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (count_q <= CNT_W'(DEPTH));
            if (i_valid && !i_flush && !o_ready)
                $warning("fetch_queue: i_valid while full, instruction dropped");
            if (pop && last_pc_vld_q)
                assert (o_pc == last_pc_q + ADDR_WIDTH'(4));
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a queue model checked every cycle plus
// hand-computed expectations for each scenario.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 26;
    localparam int DW    = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            i_flush = 1'b0;
    logic            i_valid = 1'b0;
    logic [AW-1:0]   i_pc = '0;
    logic [DW-1:0]   i_instr = '0;
    logic            o_ready;
    logic            o_almost_full;
    logic            o_valid;
    logic [AW-1:0]   o_pc;
    logic [DW-1:0]   o_instr;
    logic            i_ready = 1'b0;
    logic [$clog2(DEPTH):0] o_count;

    int passed = 0;
    int total  = 0;

    fetch_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid),
        .i_pc(i_pc), .i_instr(i_instr), .o_ready(o_ready),
        .o_almost_full(o_almost_full), .o_valid(o_valid), .o_pc(o_pc),
        .o_instr(o_instr), .i_ready(i_ready), .o_count(o_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    // model: entries as {pc, instr}
    logic [AW+DW-1:0] exp_q[$];

    always @(negedge rst_n) exp_q.delete();

    always @(posedge clk) begin
        if (!rst_n || i_flush) begin
            exp_q.delete();
        end else begin
            logic do_push, do_pop;
            do_push = i_valid && (exp_q.size() < DEPTH);
            do_pop  = i_ready && (exp_q.size() != 0);
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back({i_pc, i_instr});
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    // per-cycle compare against the model
    always @(negedge clk) begin
        int n;
        n = exp_q.size();
        chk("m_count", 64'(o_count), 64'(n));
        chk("m_valid", 64'(o_valid), 64'(n != 0));
        chk("m_ready", 64'(o_ready), 64'(n < DEPTH));
        chk("m_afull", 64'(o_almost_full), 64'(n >= DEPTH - 1));
        chk("m_pc",    64'(o_pc),    n != 0 ? 64'(exp_q[0][AW+DW-1:DW]) : 64'd0);
        chk("m_instr", 64'(o_instr), n != 0 ? 64'(exp_q[0][DW-1:0])     : 64'd0);
    end

    // driver tasks
    function automatic logic [DW-1:0] mk_instr(input logic [AW-1:0] pc);
        return 32'hC0DE_0000 | 32'(pc[15:0]);
    endfunction

    task automatic drive(input logic v, input logic [AW-1:0] pc, input logic rdy, input logic fl);
        i_valid = v;
        i_pc    = pc;
        i_instr = mk_instr(pc);
        i_ready = rdy;
        i_flush = fl;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        drive(1'b0, '0, 1'b0, 1'b1);
        cyc();
    endtask

    initial begin
        // reset
        #12;
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_afull", 64'(o_almost_full), 64'd0);
        chk("rst_count", 64'(o_count), 64'd0);
        chk("rst_pc",    64'(o_pc), 64'd0);
        chk("rst_instr", 64'(o_instr), 64'd0);
        rst_n = 1'b1;
        cyc();

        // 1: streaming
        drive(1'b1, 26'h0, 1'b1, 1'b0);
        chk("s1_c1_valid", 64'(o_valid), 64'd0);
        cyc();
        chk("s1_c2_pc", 64'(o_pc), 64'h0);
        chk("s1_c2_instr", 64'(o_instr), 64'hC0DE_0000);
        chk("s1_c2_count", 64'(o_count), 64'd1);
        drive(1'b1, 26'h4, 1'b1, 1'b0);
        cyc();
        chk("s1_c3_pc", 64'(o_pc), 64'h4);
        chk("s1_c3_count", 64'(o_count), 64'd1);
        drive(1'b1, 26'h8, 1'b1, 1'b0);
        cyc();
        chk("s1_c4_pc", 64'(o_pc), 64'h8);
        drive(1'b0, '0, 1'b1, 1'b0);
        cyc();
        chk("s1_empty", 64'(o_valid), 64'd0);

        // 2: fill under stall
        do_flush();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 26'(4 * k), 1'b0, 1'b0);
            cyc();
            chk("s2_count", 64'(o_count), 64'(k + 1));
            chk("s2_afull", 64'(o_almost_full), 64'(k + 1 >= 3));
            chk("s2_ready", 64'(o_ready), 64'(k + 1 < 4));
        end
        drive(1'b1, 26'h10, 1'b0, 1'b0);
        cyc();
        chk("s2_drop_count", 64'(o_count), 64'd4);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            chk("s2_pop_pc", 64'(o_pc), 64'(4 * k));
            cyc();
        end
        chk("s2_end_valid", 64'(o_valid), 64'd0);
        chk("s2_end_instr", 64'(o_instr), 64'd0);

        // 3: push+pop at count 2 across the wrap
        do_flush();
        drive(1'b1, 26'h0, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 26'h4, 1'b0, 1'b0);
        cyc();
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 26'(8 + 4 * k), 1'b1, 1'b0);
            chk("s3_head", 64'(o_pc), 64'(4 * k));
            cyc();
            chk("s3_count", 64'(o_count), 64'd2);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("s3_drain0", 64'(o_pc), 64'h18);
        cyc();
        chk("s3_drain1", 64'(o_pc), 64'h1C);
        cyc();
        chk("s3_empty", 64'(o_count), 64'd0);

        // 4: flush with concurrent push and pop
        do_flush();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 26'(4 * k), 1'b0, 1'b0);
            cyc();
        end
        chk("s4_pre_count", 64'(o_count), 64'd3);
        drive(1'b1, 26'h10, 1'b1, 1'b1);
        cyc();
        chk("s4_count", 64'(o_count), 64'd0);
        chk("s4_valid", 64'(o_valid), 64'd0);
        drive(1'b1, 26'h100, 1'b0, 1'b0);
        cyc();
        chk("s4_new_pc", 64'(o_pc), 64'h100);
        chk("s4_new_count", 64'(o_count), 64'd1);
        drive(1'b0, '0, 1'b1, 1'b0);
        cyc();
        chk("s4_gone", 64'(o_valid), 64'd0);

        // 5: asynchronous reset between edges
        do_flush();
        drive(1'b1, 26'h0, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 26'h4, 1'b0, 1'b0);
        cyc();
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("s5_pre_count", 64'(o_count), 64'd2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("s5_rst_valid", 64'(o_valid), 64'd0);
        chk("s5_rst_count", 64'(o_count), 64'd0);
        cyc();
        rst_n = 1'b1;
        drive(1'b1, 26'h0, 1'b1, 1'b0);
        chk("s5_c1_valid", 64'(o_valid), 64'd0);
        cyc();
        chk("s5_c2_pc", 64'(o_pc), 64'h0);
        chk("s5_c2_count", 64'(o_count), 64'd1);
        drive(1'b0, '0, 1'b1, 1'b0);
        cyc();

        // 6: pop on empty
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            cyc();
            chk("s6_count", 64'(o_count), 64'd0);
            chk("s6_pc", 64'(o_pc), 64'd0);
            chk("s6_instr", 64'(o_instr), 64'd0);
        end
        drive(1'b1, 26'h4, 1'b1, 1'b0);
        cyc();
        chk("s6_after_pc", 64'(o_pc), 64'h4);
        drive(1'b0, '0, 1'b1, 1'b0);
        cyc();
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Small instruction buffer between the synchronous i_cache output and the decode stage.
- Captures (pc, instruction) pairs produced by the fetch path and presents them in order to decode.
- Absorbs decode stalls and the one-cycle i_cache request latency without losing in-flight fetches.
- Flushed on any PC redirect (branch or jump resolution) so that wrong-path instructions never reach decode.

Parameters:
- DEPTH, 4: number of entries. Power of two, at least 2.
- ADDR_WIDTH, 26: byte-address width of the pc field.
- DATA_WIDTH, 32: instruction width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assertion, active-low.
- i_flush  in  1  redirect this cycle (same signal as the load-pc write enable).
- i_valid  in  1  i_cache delivers a valid instruction this cycle.
- i_pc  in  ADDR_WIDTH  byte address of the delivered instruction.
- i_instr  in  DATA_WIDTH  delivered instruction word.
- o_ready  out  1  queue can accept a push this cycle.
- o_almost_full  out  1  at most one free slot; fetch stalls PC advance on this.
- o_valid  out  1  head entry valid.
- o_pc  out  ADDR_WIDTH  pc of the head entry.
- o_instr  out  DATA_WIDTH  instruction of the head entry.
- i_ready  in  1  decode accepts the head this cycle (not stalled).
- o_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: circular buffer with head and tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus an occupancy counter. The counter alone decides full and empty; pointer equality is never used for this.
- Reset (rst_n low, asynchronous): head = tail = count = 0. Storage contents are don't-care. Outputs in reset: o_valid=0, o_ready=1, o_almost_full=0, o_count=0, o_pc=0, o_instr=0.
- Combinational outputs, derived from registered state only (no path from i_valid or i_instr):
  - o_ready = (count < DEPTH)
  - o_almost_full = (count >= DEPTH-1)
  - o_valid = (count != 0)
- Head data is shown ahead: o_pc and o_instr equal the head entry when o_valid=1, and are forced to 0 (MIPS nop) when o_valid=0.
- push = i_valid & o_ready & ~i_flush. Writes the entry at tail; tail increments.
- pop = o_valid & i_ready & ~i_flush. Head increments.
- Count update: count += push - pop.
- Push and pop in the same cycle: count unchanged; both pointers advance.
- Latency: an entry pushed in cycle N is visible at the head in cycle N+1 at the earliest. There is no same-cycle bypass, even when the queue is empty.
- Full: i_valid while o_ready=0 is dropped. This is an upstream protocol error, prevented by fetch stalling on o_almost_full. Pop-while-full still frees a slot, but o_ready was already low this cycle, so no push happens that cycle.
- Empty: i_ready is ignored; pointers and count hold.
- Flush has priority over everything:
  - Next cycle: head = tail = count = 0.
  - A push or pop presented in the flush cycle has no effect.
  - The instruction arriving in the cycle after the flush belongs to the new PC and is accepted normally.
- Reset mid-operation clears all state immediately, regardless of clk.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble. FIFO order is preserved across the wrap.
- Assertions (simulation only):
  - count never exceeds DEPTH.
  - No push is attempted while o_ready=0 and i_flush=0.
  - pcs at the head increase by 4 between consecutive pops unless a flush occurred in between.

Test Plan:
1. Reset then streaming: push pc 0x0, 0x4, 0x8 with i_ready=1 on consecutive cycles. Head shows pc 0x0 in cycle 2, 0x4 in cycle 3, 0x8 in cycle 4. o_count peaks at 1. o_valid=0 in cycle 1.
2. Fill under stall, DEPTH=4, i_ready=0: push 4 instructions. o_almost_full rises at count=3, o_ready falls at count=4, and a 5th i_valid is dropped. Release i_ready: pops return pc 0x0, 0x4, 0x8, 0xC in order, then o_valid=0 with o_instr=0.
3. Simultaneous push and pop at count=2: count stays 2, head advances by one entry, the new entry lands at the tail. Repeat 6 cycles so tail wraps; order stays intact.
4. Flush with count=3 plus a concurrent push (pc 0x10) and pop: next cycle count=0, o_valid=0, and pc 0x10 is absent. A push of pc 0x100 the following cycle appears as head one cycle later.
5. Asynchronous reset: assert rst_n low between clock edges with count=2. o_valid=0 and o_count=0 before the next edge. After release, the first push behaves as in scenario 1.
6. Empty pop: i_ready=1 with count=0 for 3 cycles. Pointers and count stay unchanged; o_pc=0 and o_instr=0.
